riscv_lsu: RTL and testbench

RISCV_LSU -- requirements
Module: riscv_lsu

---
 rtl/riscv_lsu.sv | 194 +++++++++++++++++++
 tb/tb_riscv_lsu.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// riscv_lsu: single-outstanding load/store unit between a RISC-V core and a
// simple ready-handshake memory. Byte enables, lane-replicated write data
// and the address are driven combinationally from the core inputs. Load data
// is extracted and extended on the edge where the memory completes, then
// held on core_rd_o until the next load completes.
//
// Optional build macro: LSU_MISALIGN_CHECK_EN adds misalign_o. A misaligned
// H/HU/W access is then never issued to memory; it stalls one cycle and
// reports misalign_o during the following RESP cycle.
module riscv_lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
`ifdef LSU_MISALIGN_CHECK_EN
    output logic        misalign_o,
`endif
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    state_e      state_q, state_d;
    logic [31:0] rd_q, rd_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d;
    logic        capture;
    logic [2:0]  cap_size;
    logic [1:0]  cap_off;

    // Select the addressed lane of a read word and extend it to 32 bits.
    function automatic logic [31:0] extract_load(input logic [2:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        case (off)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    return {{24{byte_v[7]}}, byte_v};
            SZ_BU:   return {24'd0, byte_v};
            SZ_H:    return {{16{half_v[15]}}, half_v};
            SZ_HU:   return {16'd0, half_v};
            SZ_W:    return word;
            default: return 32'd0;
        endcase
    endfunction

`ifdef LSU_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    logic misaligned;

    // Halfwords need an even address, words a 4-byte-aligned address.
    always_comb begin
        case (core_size_i)
            SZ_H, SZ_HU: misaligned = core_addr_i[0];
            SZ_W:        misaligned = |core_addr_i[1:0];
            default:     misaligned = 1'b0;
        endcase
    end

    assign misalign_o = misalign_q;
`endif

    // Combinational pass-throughs to the memory side.
    assign mem_addr_o = core_addr_i;
    assign mem_we_o   = core_we_i;
    assign core_rd_o  = rd_q;

    // Byte enables and lane-replicated store data from size and offset.
    always_comb begin
        case (core_size_i)
            SZ_B, SZ_BU: mem_be_o = 4'b0001 << core_addr_i[1:0];
            SZ_H, SZ_HU: mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
            SZ_W:        mem_be_o = 4'b1111;
            default:     mem_be_o = 4'b0000;
        endcase
        case (core_size_i)
            SZ_B:    mem_wd_o = {4{core_wd_i[7:0]}};
            SZ_H:    mem_wd_o = {2{core_wd_i[15:0]}};
            SZ_W:    mem_wd_o = core_wd_i;
            default: mem_wd_o = 32'd0;
        endcase
    end

    // Next state, handshake outputs and load-capture control.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d      = state_q;
        size_d       = size_q;
        off_d        = off_q;
        we_d         = we_q;
        capture      = 1'b0;
        mem_req_o    = 1'b0;
        core_stall_o = 1'b0;
        cap_size     = core_size_i;
        cap_off      = core_addr_i[1:0];
`ifdef LSU_MISALIGN_CHECK_EN
        misalign_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                mem_req_o    = core_req_i;
                core_stall_o = core_req_i;
                if (core_req_i) begin
                    size_d = core_size_i;
                    off_d  = core_addr_i[1:0];
                    we_d   = core_we_i;
`ifdef LSU_MISALIGN_CHECK_EN
                    if (misaligned) begin
                        mem_req_o  = 1'b0;
                        misalign_d = 1'b1;
                        state_d    = RESP;
                    end else
`endif
                    if (mem_ready_i) begin
                        capture = ~core_we_i;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                mem_req_o    = 1'b1;
                core_stall_o = 1'b1;
                cap_size     = size_q;
                cap_off      = off_q;
                if (mem_ready_i) begin
                    capture = ~we_q;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_d = capture ? extract_load(cap_size, cap_off, mem_rd_i) : rd_q;

    // State and load-data registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            rd_q       <= 32'd0;
            size_q     <= 3'd0;
            off_q      <= 2'd0;
            we_q       <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q    <= state_d;
            rd_q       <= rd_d;
            size_q     <= size_d;
            off_q      <= off_d;
            we_q       <= we_d;
`ifdef LSU_MISALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: self-checking bench for riscv_lsu. Inputs change 1 ns after
// the rising edge, outputs are sampled on the falling edge. Expected load
// results are queued when a load is driven and popped when its RESP cycle
// is observed.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr, core_wd, core_rd;
    logic        core_stall, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_ready;
`ifdef LSU_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    riscv_lsu dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_size_i  (core_size),
        .core_addr_i  (core_addr),
        .core_wd_i    (core_wd),
        .core_rd_o    (core_rd),
        .core_stall_o (core_stall),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wd_o     (mem_wd),
        .mem_rd_i     (mem_rd),
`ifdef LSU_MISALIGN_CHECK_EN
        .misalign_o   (misalign),
`endif
        .mem_ready_i  (mem_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] wd_exp;
    } st_vec_t;

    typedef struct {
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] rd;
        logic [31:0] exp;
    } ld_vec_t;

    // Load with a given number of wait cycles; starts and ends 1 ns after an
    // edge with the DUT in IDLE.
    task automatic do_load(input string name, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] rd, input int waits, input logic [31:0] exp);
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_size = size;
        core_addr = addr;
        mem_rd    = rd;
        exp_q.push_back(exp);
        for (int i = 0; i <= waits; i++) begin
            mem_ready = (i == waits);
            @(negedge clk);
            check({name, " stall"}, {31'd0, core_stall}, 32'd1);
            check({name, " mem_req"}, {31'd0, mem_req}, 32'd1);
            @(posedge clk); #1;
        end
        core_req  = 1'b0;
        mem_ready = 1'b0;
        mem_rd    = 32'h5A5A_5A5A;
        @(negedge clk);
        check({name, " resp stall"}, {31'd0, core_stall}, 32'd0);
        check({name, " resp mem_req"}, {31'd0, mem_req}, 32'd0);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty at response", name);
        end else begin
            last_rd = exp_q.pop_front();
            check({name, " rd"}, core_rd, last_rd);
        end
        @(posedge clk); #1;
    endtask

    st_vec_t st_tab[8];
    ld_vec_t ld_tab[9];

    initial begin
        rst_n = 1'b0; core_req = 1'b0; core_we = 1'b0; core_size = 3'd0;
        core_addr = 32'd0; core_wd = 32'd0; mem_rd = 32'd0; mem_ready = 1'b0;
        last_rd = 32'd0;

        st_tab[0] = '{3'd0, 32'h3001, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB};
        st_tab[1] = '{3'd0, 32'h0003, 32'h1234_5678, 4'b1000, 32'h7878_7878};
        st_tab[2] = '{3'd4, 32'h0000, 32'h1234_5678, 4'b0001, 32'h0000_0000};
        st_tab[3] = '{3'd1, 32'h0002, 32'hCAFE_1234, 4'b1100, 32'h1234_1234};
        st_tab[4] = '{3'd5, 32'h0001, 32'hCAFE_1234, 4'b0011, 32'h0000_0000};
        st_tab[5] = '{3'd2, 32'h0005, 32'h89AB_CDEF, 4'b1111, 32'h89AB_CDEF};
        st_tab[6] = '{3'd3, 32'h0000, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000};
        st_tab[7] = '{3'd7, 32'h0002, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000};

        ld_tab[0] = '{3'd4, 32'h1002, 32'h80FF_7F01, 32'h0000_00FF};
        ld_tab[1] = '{3'd0, 32'h1002, 32'h80FF_7F01, 32'hFFFF_FFFF};
        ld_tab[2] = '{3'd0, 32'h1001, 32'h80FF_7F01, 32'h0000_007F};
        ld_tab[3] = '{3'd0, 32'h1003, 32'h80FF_7F01, 32'hFFFF_FF80};
        ld_tab[4] = '{3'd1, 32'h1000, 32'h80FF_7F01, 32'h0000_7F01};
        ld_tab[5] = '{3'd1, 32'h1002, 32'h80FF_7F01, 32'hFFFF_80FF};
        ld_tab[6] = '{3'd5, 32'h1002, 32'h80FF_7F01, 32'h0000_80FF};
        ld_tab[7] = '{3'd2, 32'h1000, 32'h80FF_7F01, 32'h80FF_7F01};
        ld_tab[8] = '{3'd6, 32'h1000, 32'h80FF_7F01, 32'h0000_0000};

        // Reset state.
        #12;
        check("reset rd", core_rd, 32'd0);
        check("reset stall", {31'd0, core_stall}, 32'd0);
        check("reset mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Combinational byte-enable / write-data / pass-through table.
        for (int i = 0; i < 8; i++) begin
            core_size = st_tab[i].size;
            core_addr = st_tab[i].addr;
            core_wd   = st_tab[i].wd;
            core_we   = i[0];
            #1;
            check($sformatf("be[%0d]", i), {28'd0, mem_be}, {28'd0, st_tab[i].be});
            check($sformatf("wd[%0d]", i), mem_wd, st_tab[i].wd_exp);
            check($sformatf("addr[%0d]", i), mem_addr, st_tab[i].addr);
            check($sformatf("we[%0d]", i), {31'd0, mem_we}, {31'd0, core_we});
        end
        core_we = 1'b0;
        @(posedge clk); #1;

        // Zero-wait load extraction table.
        for (int i = 0; i < 9; i++)
            do_load($sformatf("ld[%0d]", i), ld_tab[i].size, ld_tab[i].addr,
                    ld_tab[i].rd, 0, ld_tab[i].exp);

        // Halfword load with three wait cycles.
        do_load("ld_h_wait3", 3'd1, 32'h2002, 32'h8001_1234, 3, 32'hFFFF_8001);

        // Byte store: lanes, strobes, one-cycle stall, rd untouched.
        core_req = 1'b1; core_we = 1'b1; core_size = 3'd0;
        core_addr = 32'h3001; core_wd = 32'h0000_00AB; mem_ready = 1'b1;
        mem_rd = 32'h1111_1111;
        @(negedge clk);
        check("st be", {28'd0, mem_be}, 32'h2);
        check("st wd", mem_wd, 32'hABAB_ABAB);
        check("st we", {31'd0, mem_we}, 32'd1);
        check("st stall", {31'd0, core_stall}, 32'd1);
        @(posedge clk); #1;
        core_req = 1'b0; core_we = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("st resp stall", {31'd0, core_stall}, 32'd0);
        check("st rd kept", core_rd, last_rd);
        @(posedge clk); #1;

        // Back-to-back word loads with the request held high.
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h100;
        mem_ready = 1'b1; mem_rd = 32'h0102_0304;
        @(negedge clk);
        check("b2b c0 stall", {31'd0, core_stall}, 32'd1);
        @(posedge clk); #1;
        mem_rd = 32'hA5A5_0000;
        @(negedge clk);
        check("b2b c1 stall", {31'd0, core_stall}, 32'd0);
        check("b2b c1 mem_req", {31'd0, mem_req}, 32'd0);
        check("b2b c1 rd", core_rd, 32'h0102_0304);
        @(posedge clk); #1;
        mem_rd = 32'h0506_0708;
        @(negedge clk);
        check("b2b c2 stall", {31'd0, core_stall}, 32'd1);
        @(posedge clk); #1;
        core_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("b2b c3 stall", {31'd0, core_stall}, 32'd0);
        check("b2b c3 mem_req", {31'd0, mem_req}, 32'd0);
        check("b2b c3 rd", core_rd, 32'h0506_0708);
        last_rd = 32'h0506_0708;
        @(posedge clk); #1;

        // Reset asserted during the second wait cycle.
        core_req = 1'b1; core_size = 3'd2; core_addr = 32'h200; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstw wait stall", {31'd0, core_stall}, 32'd1);
        core_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstw rd", core_rd, 32'd0);
        check("rstw stall", {31'd0, core_stall}, 32'd0);
        check("rstw mem_req", {31'd0, mem_req}, 32'd0);
        last_rd = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_load("ld_after_rst", 3'd2, 32'h300, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);

`ifdef LSU_MISALIGN_CHECK_EN
        // Misaligned word load is not issued and flags one RESP cycle.
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h4002;
        mem_ready = 1'b1; mem_rd = 32'h7777_7777;
        @(negedge clk);
        check("mis mem_req", {31'd0, mem_req}, 32'd0);
        check("mis stall", {31'd0, core_stall}, 32'd1);
        check("mis flag idle", {31'd0, misalign}, 32'd0);
        @(posedge clk); #1;
        core_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check("mis flag resp", {31'd0, misalign}, 32'd1);
        check("mis stall resp", {31'd0, core_stall}, 32'd0);
        check("mis rd kept", core_rd, last_rd);
        @(posedge clk); #1;
        @(negedge clk);
        check("mis flag after", {31'd0, misalign}, 32'd0);
`endif

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d responses still pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
